mmap_kron_wrapper: RTL and testbench
====================================

Name: mmap_kron_wrapper

Overview:
- Streaming evaluator for the mapped Kronecker product of two serialized quadtree integer matrices, A and B.
- Consumes two AXI-Stream-style token streams back to back; each tree ends at its own i_tlast.
- Result is the sum of all elements of kron(A,B), i.e. sum(A)*sum(B) mod 2^32, presented as one tagged Int_t word.
- Top-level wrapper used in the QTree benchmark flow.

Parameters:
CNT_W, 16, width of the pending-slot counter used for tree well-formedness checking.

Ports:
aclk  in  1  clock; all state changes on rising edge
areset  in  1  reset, asynchronous, active-high
i_tdata  in  67 (QTree_Int_t)  token: bits[0:2] tag (bit 0 MSB), bits[3:34] value (bit 3 MSB), bits[35:66] weight (bit 35 MSB)
i_tlast  in  1  marks the last token of the current tree
i_tvalid  in  1  token valid
i_tready  out  1  block can accept a token
o_tready  in  1  consumer accepts the result
o_tdata  out  33 (Int_t)  bit[0] valid flag, bits[1:32] result (bit 1 MSB)

Behaviour:
- Reset (async assert, release sync to aclk): state=LOAD_A; o_tdata=0; i_tready=0 while areset high, 1 from first edge after release; sumA=sumB=0; err=0; pending=1.
- Token accepted on a rising edge with i_tvalid & i_tready.
- Tags:
  - 0 Empty: contributes 0.
  - 1 Leaf: contributes value*weight, low 32 bits.
  - 2 Node: contributes 0; its 4 children follow in preorder.
  - 3..7 reserved: treated as Empty.
- Slot counter per tree: starts at 1; every accepted token does -1; a Node additionally does +4.
  - On the tlast token the post-update count must be 0; otherwise set sticky err.
  - Count reaching 0 before tlast also sets err; further tokens still accumulate.
  - Counter saturates, never wraps.
- All arithmetic is 32-bit two's complement, truncated mod 2^32 (signed and unsigned give identical bits).
- FSM:
  - LOAD_A: accumulate into sumA. Accepting a tlast token -> LOAD_B, pending reset to 1.
  - LOAD_B: accumulate into sumB. Accepting a tlast token -> MUL.
  - MUL: i_tready=0; register product = err ? 32'hFFFF_FFFF : sumA*sumB. o_tdata[0]=1 after this edge. -> OUT.
  - OUT: i_tready=0; o_tdata held stable until an edge with o_tready=1. On that edge o_tdata clears to 0, accumulators/err/pending clear, and the FSM returns to LOAD_A.
- Latency: valid result one edge after the B-tlast accept edge. If o_tready is already 1, the result persists exactly one cycle.
- i_tready is high in LOAD_A and LOAD_B only. It is combinational from state, with no dependence on i_tvalid.
- i_tvalid gaps are allowed anywhere. i_tdata and i_tlast are ignored when not accepted.
- areset asserted mid-operation aborts everything at once, including a pending undelivered result.

Decomposition:
- Package mMapKron_package holds:
  - QTree_Int_t = logic [0:66]
  - Int_t = logic [0:32]
  - tag constants TAG_EMPTY=0, TAG_LEAF=1, TAG_NODE=2
  - field index/width constants
  - the FSM state enum
- One sub-module is natural: qtree_sum_acc (per-tree accumulator plus slot counter and err). Instantiated once and reused for A then B, with the sum latched into sumA at the A-tlast.

Test Plan:
- A=[Leaf(1,1)], B=[Leaf(1,1)], o_tready=1 -> o_tdata[0]=1, value 1, one cycle after B tlast.
- A=[Node, Leaf(2,1), Empty, Leaf(3,1), Empty], B=[Leaf(5,4)] -> sumA=5, sumB=20, result 100 (0x64).
- A=[Node, Leaf(1,1), Leaf(1,1)] with tlast on the 3rd token, B=[Leaf(7,1)] -> result 0xFFFFFFFF (malformed).
- Leaf(-3,1) (0xFFFFFFFD) as A, Leaf(4,1) as B -> result 0xFFFFFFF4. Also Leaf(0x10000,0x10000) * Leaf(1,1) -> 0 (wrap).
- Hold o_tready=0 for 5 cycles after the result -> o_tdata stable and i_tready=0 throughout. Raise o_tready -> valid drops next edge, i_tready=1, a second run computes fresh.
- Pulse areset during LOAD_B, with i_tvalid toggling randomly -> outputs 0 at once; replaying the full A,B stream gives the correct result.

Source files
------------

// File: rtl/mmap_kron_wrapper_pkg.sv
// Shared types and constants for the QTree Kronecker-sum wrapper.
// Token layout is MSB-first: tag, value, weight.
package mMapKron_package;

  typedef logic [0:66] QTree_Int_t;
  typedef logic [0:32] Int_t;

  localparam logic [2:0] TAG_EMPTY = 3'd0;
  localparam logic [2:0] TAG_LEAF  = 3'd1;
  localparam logic [2:0] TAG_NODE  = 3'd2;

  localparam int TAG_HI = 0;
  localparam int TAG_LO = 2;
  localparam int VAL_HI = 3;
  localparam int VAL_LO = 34;
  localparam int WGT_HI = 35;
  localparam int WGT_LO = 66;
  localparam int WORD_W = 32;

  // FSM state encoding
  localparam logic [1:0] ST_LOAD_A = 2'd0;
  localparam logic [1:0] ST_LOAD_B = 2'd1;
  localparam logic [1:0] ST_MUL    = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  function automatic logic [2:0] tok_tag(input QTree_Int_t t);
    return t[TAG_HI:TAG_LO];
  endfunction

  function automatic logic [WORD_W-1:0] tok_value(input QTree_Int_t t);
    return t[VAL_HI:VAL_LO];
  endfunction

  function automatic logic [WORD_W-1:0] tok_weight(input QTree_Int_t t);
    return t[WGT_HI:WGT_LO];
  endfunction

endpackage

// File: rtl/mmap_kron_wrapper_if.sv
// Token-in / result-out handshake bundle for mmap_kron_wrapper.
interface mmap_kron_wrapper_if;
  import mMapKron_package::*;

  QTree_Int_t i_tdata;
  logic       i_tlast;
  logic       i_tvalid;
  logic       i_tready;
  logic       o_tready;
  Int_t       o_tdata;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata
  );
endinterface

// File: rtl/mmap_kron_wrapper_qtree_sum_acc.sv
// Per-tree accumulator: sums leaf products and checks the preorder slot count.
// Reused for tree A then tree B; restarts itself at each tlast, err stays sticky.
module qtree_sum_acc
  import mMapKron_package::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              clr,
  input  logic              tok_en,
  input  logic              tok_last,
  input  logic [2:0]        tag,
  input  logic [WORD_W-1:0] value,
  input  logic [WORD_W-1:0] weight,
  output logic [WORD_W-1:0] sum_next,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_NODE_INC = CNT_W'(3);

  logic [WORD_W-1:0] sum_q;
  logic [WORD_W-1:0] leaf_prod;
  logic [CNT_W-1:0]  pend_q;
  logic [CNT_W-1:0]  pend_next;
  logic              bad;

  assign leaf_prod = value * weight;
  assign sum_next  = sum_q + ((tag == TAG_LEAF) ? leaf_prod : '0);

  // Node nets +3 (consumes one slot, opens four); both directions saturate
  always_comb begin
    pend_next = pend_q;
    if (tag == TAG_NODE) begin
      if (pend_q > (CNT_MAX - CNT_NODE_INC)) pend_next = CNT_MAX;
      else                                   pend_next = pend_q + CNT_NODE_INC;
    end else if (pend_q != '0) begin
      pend_next = pend_q - CNT_ONE;
    end
  end

  assign bad = tok_last ? (pend_next != '0) : (pend_next == '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sum_q  <= '0;
      pend_q <= CNT_ONE;
      err    <= 1'b0;
    end else if (clr) begin
      sum_q  <= '0;
      pend_q <= CNT_ONE;
      err    <= 1'b0;
    end else if (tok_en) begin
      err <= err | bad;
      if (tok_last) begin
        sum_q  <= '0;
        pend_q <= CNT_ONE;
      end else begin
        sum_q  <= sum_next;
        pend_q <= pend_next;
      end
    end
  end

endmodule

// File: rtl/mmap_kron_wrapper.sv
// Streaming sum(kron(A,B)) = sum(A)*sum(B) over two serialized quadtrees.
//
// state   | meaning
// LOAD_A  | accepting tree A tokens into the accumulator
// LOAD_B  | accepting tree B tokens, sum(A) already latched
// MUL     | one cycle: register product (or all-ones on malformed input)
// OUT     | hold tagged result until o_tready
module mmap_kron_wrapper
  import mMapKron_package::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                aclk,
  input  logic                areset,
  mmap_kron_wrapper_if.slave  bus
);

  logic [1:0]        state_q;
  logic              run_q;
  logic [WORD_W-1:0] sum_a_q;
  logic [WORD_W-1:0] sum_b_q;
  logic [WORD_W-1:0] product;
  logic [WORD_W-1:0] acc_sum_next;
  logic              acc_err;
  logic              tok_en;
  logic              done_clr;
  Int_t              o_q;

  // run_q keeps i_tready low until the first edge after reset release
  assign bus.i_tready = run_q & ((state_q == ST_LOAD_A) || (state_q == ST_LOAD_B));
  assign bus.o_tdata  = o_q;
  assign tok_en       = bus.i_tvalid & bus.i_tready;
  assign done_clr     = (state_q == ST_OUT) & bus.o_tready;
  assign product      = sum_a_q * sum_b_q;

  qtree_sum_acc #(.CNT_W(CNT_W)) u_acc (
    .aclk     (aclk),
    .areset   (areset),
    .clr      (done_clr),
    .tok_en   (tok_en),
    .tok_last (bus.i_tlast),
    .tag      (tok_tag(bus.i_tdata)),
    .value    (tok_value(bus.i_tdata)),
    .weight   (tok_weight(bus.i_tdata)),
    .sum_next (acc_sum_next),
    .err      (acc_err)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_LOAD_A;
      run_q   <= 1'b0;
      sum_a_q <= '0;
      sum_b_q <= '0;
      o_q     <= '0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        ST_LOAD_A: if (tok_en && bus.i_tlast) begin
          sum_a_q <= acc_sum_next;
          state_q <= ST_LOAD_B;
        end
        ST_LOAD_B: if (tok_en && bus.i_tlast) begin
          sum_b_q <= acc_sum_next;
          state_q <= ST_MUL;
        end
        ST_MUL: begin
          o_q     <= {1'b1, (acc_err ? 32'hFFFF_FFFF : product)};
          state_q <= ST_OUT;
        end
        default: if (bus.o_tready) begin
          o_q     <= '0;
          sum_a_q <= '0;
          sum_b_q <= '0;
          state_q <= ST_LOAD_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmap_kron_wrapper.sv
// Directed bench for mmap_kron_wrapper with hand-computed expected results.
module tb_mmap_kron_wrapper;
  import mMapKron_package::*;

  logic aclk = 1'b0;
  logic areset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  QTree_Int_t tq[$];
  logic       lq[$];

  mmap_kron_wrapper_if bus ();

  mmap_kron_wrapper #(.CNT_W(16)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic add_tok(input logic [2:0] tg, input logic [31:0] v, input logic [31:0] w,
                         input logic last);
    QTree_Int_t t;
    t = {tg, v, w};
    tq.push_back(t);
    lq.push_back(last);
  endtask

  // Entered and left at a negedge; leaves at the negedge after the last accept
  task automatic send_all(input bit gaps);
    logic [95:0] r;
    int n;
    for (int i = 0; i < tq.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          r = {$urandom(), $urandom(), $urandom()};
          bus.i_tvalid = 1'b0;
          bus.i_tdata  = r[66:0];
          bus.i_tlast  = r[67];
          @(negedge aclk);
        end
      end
      bus.i_tdata  = tq[i];
      bus.i_tlast  = lq[i];
      bus.i_tvalid = 1'b1;
      n = 0;
      while (!bus.i_tready && n < 50) begin
        @(negedge aclk);
        n++;
      end
      if (n == 50) begin
        check_val("send_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge aclk);
      @(negedge aclk);
    end
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
    tq.delete();
    lq.delete();
  endtask

  task automatic get_result(input string tag, input logic [31:0] exp, input bit rdy);
    Int_t want;
    want = {1'b1, exp};
    check_val({tag, "_lat"}, 64'(bus.o_tdata), 64'd0);
    check_val({tag, "_rdy_mul"}, 64'(bus.i_tready), 64'd0);
    @(negedge aclk);
    check_val({tag, "_res"}, 64'(bus.o_tdata), 64'(want));
    if (rdy) begin
      @(negedge aclk);
      check_val({tag, "_clr"}, 64'(bus.o_tdata), 64'd0);
      check_val({tag, "_rdy_back"}, 64'(bus.i_tready), 64'd1);
    end
  endtask

  task automatic push_a7();
    add_tok(TAG_NODE,  32'd0, 32'd0, 1'b0);
    add_tok(TAG_LEAF,  32'd2, 32'd3, 1'b0);
    add_tok(TAG_LEAF,  32'd1, 32'd1, 1'b0);
    add_tok(TAG_EMPTY, 32'd0, 32'd0, 1'b0);
    add_tok(TAG_LEAF,  32'd4, 32'hFFFF_FFFF, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Int_t held;
    bus.i_tvalid = 1'b0;
    bus.i_tdata  = '0;
    bus.i_tlast  = 1'b0;
    bus.o_tready = 1'b1;
    #1 areset = 1'b1;
    #1;
    check_val("rst_o", 64'(bus.o_tdata), 64'd0);
    check_val("rst_rdy", 64'(bus.i_tready), 64'd0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    check_val("rel_rdy0", 64'(bus.i_tready), 64'd0);
    @(negedge aclk);
    check_val("rel_rdy1", 64'(bus.i_tready), 64'd1);

    // single leaves
    add_tok(TAG_LEAF, 32'd1, 32'd1, 1'b1);
    add_tok(TAG_LEAF, 32'd1, 32'd1, 1'b1);
    send_all(1'b0);
    get_result("t1", 32'd1, 1'b1);

    // 5 * 20 = 100
    add_tok(TAG_NODE,  32'd0, 32'd0, 1'b0);
    add_tok(TAG_LEAF,  32'd2, 32'd1, 1'b0);
    add_tok(TAG_EMPTY, 32'd0, 32'd0, 1'b0);
    add_tok(TAG_LEAF,  32'd3, 32'd1, 1'b0);
    add_tok(TAG_EMPTY, 32'd0, 32'd0, 1'b1);
    add_tok(TAG_LEAF,  32'd5, 32'd4, 1'b1);
    send_all(1'b1);
    get_result("t2", 32'h64, 1'b1);

    // truncated tree: tlast with two slots still open
    add_tok(TAG_NODE, 32'd0, 32'd0, 1'b0);
    add_tok(TAG_LEAF, 32'd1, 32'd1, 1'b0);
    add_tok(TAG_LEAF, 32'd1, 32'd1, 1'b1);
    add_tok(TAG_LEAF, 32'd7, 32'd1, 1'b1);
    send_all(1'b0);
    get_result("t3", 32'hFFFF_FFFF, 1'b1);

    // tree complete before its tlast
    add_tok(TAG_LEAF, 32'd1, 32'd1, 1'b0);
    add_tok(TAG_LEAF, 32'd1, 32'd1, 1'b1);
    add_tok(TAG_LEAF, 32'd2, 32'd2, 1'b1);
    send_all(1'b0);
    get_result("t3b", 32'hFFFF_FFFF, 1'b1);

    // signed: -3 * 4
    add_tok(TAG_LEAF, 32'hFFFF_FFFD, 32'd1, 1'b1);
    add_tok(TAG_LEAF, 32'd4, 32'd1, 1'b1);
    send_all(1'b0);
    get_result("t4a", 32'hFFFF_FFF4, 1'b1);

    // leaf product wraps to 0
    add_tok(TAG_LEAF, 32'h0001_0000, 32'h0001_0000, 1'b1);
    add_tok(TAG_LEAF, 32'd1, 32'd1, 1'b1);
    send_all(1'b0);
    get_result("t4b", 32'd0, 1'b1);

    // reserved tag behaves as Empty: 7 * 4 = 28
    add_tok(TAG_NODE,  32'd0, 32'd0, 1'b0);
    add_tok(TAG_LEAF,  32'd3, 32'd2, 1'b0);
    add_tok(3'd7,      32'd9, 32'd9, 1'b0);
    add_tok(TAG_EMPTY, 32'd0, 32'd0, 1'b0);
    add_tok(TAG_LEAF,  32'd1, 32'd1, 1'b1);
    add_tok(TAG_NODE,  32'd0, 32'd0, 1'b0);
    add_tok(TAG_LEAF,  32'd2, 32'd2, 1'b0);
    add_tok(3'd5,      32'd8, 32'd8, 1'b0);
    add_tok(TAG_EMPTY, 32'd0, 32'd0, 1'b0);
    add_tok(TAG_EMPTY, 32'd0, 32'd0, 1'b1);
    send_all(1'b1);
    get_result("t5", 32'd28, 1'b1);

    // backpressure: hold result for 5 cycles
    bus.o_tready = 1'b0;
    add_tok(TAG_LEAF, 32'd3, 32'd3, 1'b1);
    add_tok(TAG_LEAF, 32'd2, 32'd1, 1'b1);
    send_all(1'b0);
    get_result("t6", 32'd18, 1'b0);
    held = {1'b1, 32'd18};
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check_val("t6_hold", 64'(bus.o_tdata), 64'(held));
      check_val("t6_hold_rdy", 64'(bus.i_tready), 64'd0);
    end
    bus.o_tready = 1'b1;
    @(negedge aclk);
    check_val("t6_drop", 64'(bus.o_tdata), 64'd0);
    check_val("t6_rdy", 64'(bus.i_tready), 64'd1);
    add_tok(TAG_LEAF, 32'd6, 32'd1, 1'b1);
    add_tok(TAG_LEAF, 32'd7, 32'd1, 1'b1);
    send_all(1'b0);
    get_result("t6b", 32'd42, 1'b1);

    // reset in LOAD_B, then full replay: 3 * 25 = 75
    push_a7();
    add_tok(TAG_NODE, 32'd0, 32'd0, 1'b0);
    add_tok(TAG_LEAF, 32'd9, 32'd9, 1'b0);
    send_all(1'b1);
    areset = 1'b1;
    #1;
    check_val("t7_rst_o", 64'(bus.o_tdata), 64'd0);
    check_val("t7_rst_rdy", 64'(bus.i_tready), 64'd0);
    @(negedge aclk);
    check_val("t7_rst_rdy2", 64'(bus.i_tready), 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    check_val("t7_rel_rdy", 64'(bus.i_tready), 64'd1);
    push_a7();
    add_tok(TAG_LEAF, 32'd5, 32'd5, 1'b1);
    send_all(1'b1);
    get_result("t7", 32'd75, 1'b1);

    // reset drops an undelivered result
    bus.o_tready = 1'b0;
    add_tok(TAG_LEAF, 32'd2, 32'd2, 1'b1);
    add_tok(TAG_LEAF, 32'd2, 32'd2, 1'b1);
    send_all(1'b0);
    get_result("t8", 32'd16, 1'b0);
    areset = 1'b1;
    #1;
    check_val("t8_abort", 64'(bus.o_tdata), 64'd0);
    @(negedge aclk);
    areset = 1'b0;
    bus.o_tready = 1'b1;
    @(negedge aclk);
    add_tok(TAG_LEAF, 32'd1, 32'd1, 1'b1);
    add_tok(TAG_LEAF, 32'd3, 32'd1, 1'b1);
    send_all(1'b0);
    get_result("t8b", 32'd3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
